rv32i_core: RTL and testbench
=============================

Name: rv32i_core

Overview:
- Single-cycle RV32I integer core (base subset) for the didactic platform.
- Fetches 32-bit instructions from an external instruction ROM and accesses an external word-addressed data RAM.
- Contains the PC, the decoder, the ALU, the branch unit and a 32x32 register file.
- Instance name of the register file is reg_file_inst; its storage array is registers[0:31], hierarchically readable by benches.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  reset; synchronous, active-high (asserted = 1). Port name kept for codebase compatibility.
- instruction  in  32  instruction word from ROM, combinationally valid for current rom_addr.
- mem_rd_data  in  32  RAM read data, combinationally valid for current mem_addr.
- mem_wr_sig  out  1  RAM write enable; RAM writes mem_wr_data at mem_addr on rising edge.
- mem_wr_data  out  32  store data (rs2 value).
- mem_addr  out  32  data byte address (rs1 + imm).
- rom_addr  out  32  instruction byte address (= PC).

Behaviour:
- Reset (reset_n=1 at rising edge):
  - PC <= RESET_PC; all 32 registers <= 0.
  - While reset is held: mem_wr_sig=0, rom_addr=RESET_PC; no register writes.
- One instruction retires per clock, with no pipeline and no stalls.
- Combinational in-cycle path: instruction -> decode -> reg read -> ALU -> mem -> writeback mux.
- Rising edge commits: rd write, PC update, RAM write.
- x0 reads 0; writes to x0 are discarded.
- Register file: two asynchronous read ports, one synchronous write port. Reading a register in the cycle it is written returns the old value.
- Supported instructions:
  - LUI, AUIPC.
  - JAL, JALR: rd = PC+4; JALR target = (rs1+imm) & ~1.
  - BEQ/BNE/BLT/BGE/BLTU/BGEU: target PC+imm; not taken -> PC+4.
  - LW: rd = mem_rd_data.
  - SW: mem_wr_sig=1 for exactly that cycle.
  - ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI.
  - ADD/SUB/SLL/SLT/SLTU/XOR/OR/AND/SRL/SRA.
- Arithmetic: 32-bit wrap-around, no overflow traps. Shift amount = low 5 bits. SLT/BLT/BGE are signed; SLTU/BLTU/BGEU are unsigned.
- Immediates are sign-extended per I/S/B/U/J formats; B and J immediates have bit0 = 0.
- Loads/stores ignore funct3 and are always full word; mem_addr is output unmodified. The RAM uses addr[..:2].
- FENCE, ECALL, EBREAK and any unrecognised opcode execute as NOP: PC+4, no rd write, mem_wr_sig=0.
- mem_wr_sig is 0 for every non-store instruction; mem_addr and mem_wr_data are don't-care then.
- Misaligned jump/branch targets are not trapped; PC takes the computed value.
- PC wraps modulo 2^32.
- Reset asserted mid-program overrides any in-flight commit that cycle: no register write, no RAM write.

Test Plan:
- Reset: hold reset 2 cycles with ROM full of ADDI x1,x1,1 -> rom_addr=0, all registers 0, mem_wr_sig=0; after release, x1=1 after 1 cycle, rom_addr=4.
- Fibonacci program (iterative loop, result in x3), release reset, run 500 cycles -> registers[3]=55.
- ALU: ADDI x1,x0,-8; SRAI x2,x1,1; SRLI x3,x1,28; SLT x4,x1,x0; SLTU x5,x1,x0 -> x2=0xFFFFFFFC, x3=0xF, x4=1, x5=0.
- Memory round trip: ADDI x1,x0,0x55; SW x1,8(x0); LW x2,8(x0) -> mem_wr_sig high only in the SW cycle with mem_addr=8 and mem_wr_data=0x55; x2=0x55.
- Control flow: JAL x1,+8 at PC 0 -> x1=4, PC=8. BNE x0,x0,+16 -> PC+4. BEQ x0,x0,-8 -> PC-8. JALR x0,5(x0) -> PC=4.
- x0 and NOP: ADDI x0,x0,7 then opcode 0x00 -> x0 reads 0, no register changes, PC advances by 4 each cycle.

Source files
------------

// File: rtl/rv32i_core.sv
// Single-cycle RV32I base-subset core: PC, decoder, ALU, branch unit and a 32x32 register file.
// Instructions come from an external ROM; loads/stores go to an external word-addressed RAM.

module rv32i_reg_file (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  output logic [31:0] rdata1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata2
);

  logic [31:0] registers [0:31];

  // Synchronous write; x0 is never written so it stays zero after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        registers[i] <= '0;
      end
    end else if (we && (waddr != 5'd0)) begin
      registers[waddr] <= wdata;
    end
  end

  // Asynchronous reads return the pre-edge value when the same register is being written.
  assign rdata1 = (raddr1 == 5'd0) ? 32'h0 : registers[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? 32'h0 : registers[raddr2];

endmodule

module rv32i_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] instruction,
  input  logic [31:0] mem_rd_data,
  output logic        mem_wr_sig,
  output logic [31:0] mem_wr_data,
  output logic [31:0] mem_addr,
  output logic [31:0] rom_addr
);

  localparam int unsigned XLEN = 32;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
  } alu_op_t;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] pc_plus4;

  logic [6:0]      opcode;
  logic [4:0]      rd_addr;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic [2:0]      funct3;
  logic            funct7_alt;

  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;

  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] rd_wdata;
  logic            rd_we;
  logic            is_store;

  alu_op_t         alu_op;
  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] alu_y;
  logic [XLEN-1:0] jalr_sum;
  logic            branch_taken;

  assign opcode     = instruction[6:0];
  assign rd_addr    = instruction[11:7];
  assign funct3     = instruction[14:12];
  assign rs1_addr   = instruction[19:15];
  assign rs2_addr   = instruction[24:20];
  assign funct7_alt = instruction[30];

  assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
  assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                  instruction[30:25], instruction[11:8], 1'b0};
  assign imm_u = {instruction[31:12], 12'h000};
  assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                  instruction[20], instruction[30:21], 1'b0};

  rv32i_reg_file reg_file_inst (
    .clk    (clk),
    .reset  (reset_n),
    .we     (rd_we),
    .waddr  (rd_addr),
    .wdata  (rd_wdata),
    .raddr1 (rs1_addr),
    .rdata1 (rs1_data),
    .raddr2 (rs2_addr),
    .rdata2 (rs2_data)
  );

  assign pc_plus4 = pc + XLEN'(4);
  assign jalr_sum = rs1_data + imm_i;

  // Program counter; reset overrides the in-flight commit.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

  // Branch comparator; reserved funct3 encodings fall through as not taken.
  always_comb begin
    branch_taken = 1'b0;
    case (funct3)
      3'b000:  branch_taken = (rs1_data == rs2_data);
      3'b001:  branch_taken = (rs1_data != rs2_data);
      3'b100:  branch_taken = ($signed(rs1_data) <  $signed(rs2_data));
      3'b101:  branch_taken = ($signed(rs1_data) >= $signed(rs2_data));
      3'b110:  branch_taken = (rs1_data <  rs2_data);
      3'b111:  branch_taken = (rs1_data >= rs2_data);
      default: branch_taken = 1'b0;
    endcase
  end

  // ALU operation select; the alternate bit only means SUB/SRA where the ISA defines it.
  always_comb begin
    alu_op = ALU_ADD;
    case (funct3)
      3'b000: alu_op = (opcode == OP_REG && funct7_alt) ? ALU_SUB : ALU_ADD;
      3'b001: alu_op = ALU_SLL;
      3'b010: alu_op = ALU_SLT;
      3'b011: alu_op = ALU_SLTU;
      3'b100: alu_op = ALU_XOR;
      3'b101: alu_op = funct7_alt ? ALU_SRA : ALU_SRL;
      3'b110: alu_op = ALU_OR;
      3'b111: alu_op = ALU_AND;
      default: alu_op = ALU_ADD;
    endcase
  end

  assign alu_b = (opcode == OP_REG) ? rs2_data : imm_i;

  always_comb begin
    alu_y = '0;
    case (alu_op)
      ALU_ADD:  alu_y = rs1_data + alu_b;
      ALU_SUB:  alu_y = rs1_data - alu_b;
      ALU_SLL:  alu_y = rs1_data << alu_b[4:0];
      ALU_SLT:  alu_y = {{(XLEN-1){1'b0}}, ($signed(rs1_data) < $signed(alu_b))};
      ALU_SLTU: alu_y = {{(XLEN-1){1'b0}}, (rs1_data < alu_b)};
      ALU_XOR:  alu_y = rs1_data ^ alu_b;
      ALU_SRL:  alu_y = rs1_data >> alu_b[4:0];
      ALU_SRA:  alu_y = XLEN'($signed(rs1_data) >>> alu_b[4:0]);
      ALU_OR:   alu_y = rs1_data | alu_b;
      ALU_AND:  alu_y = rs1_data & alu_b;
      default:  alu_y = '0;
    endcase
  end

  // Decode: next PC, writeback value and enables; unknown opcodes behave as NOP.
  always_comb begin
    pc_next  = pc_plus4;
    rd_we    = 1'b0;
    rd_wdata = alu_y;
    is_store = 1'b0;
    case (opcode)
      OP_LUI: begin
        rd_we    = 1'b1;
        rd_wdata = imm_u;
      end
      OP_AUIPC: begin
        rd_we    = 1'b1;
        rd_wdata = pc + imm_u;
      end
      OP_JAL: begin
        rd_we    = 1'b1;
        rd_wdata = pc_plus4;
        pc_next  = pc + imm_j;
      end
      OP_JALR: begin
        rd_we    = 1'b1;
        rd_wdata = pc_plus4;
        pc_next  = jalr_sum & ~XLEN'(1);
      end
      OP_BRANCH: begin
        if (branch_taken) begin
          pc_next = pc + imm_b;
        end
      end
      OP_LOAD: begin
        rd_we    = 1'b1;
        rd_wdata = mem_rd_data;
      end
      OP_STORE: begin
        is_store = 1'b1;
      end
      OP_IMM, OP_REG: begin
        rd_we    = 1'b1;
        rd_wdata = alu_y;
      end
      default: begin
        rd_we = 1'b0;
      end
    endcase
    if (reset_n) begin
      rd_we = 1'b0;
    end
  end

  assign rom_addr    = pc;
  assign mem_addr    = rs1_data + (is_store ? imm_s : imm_i);
  assign mem_wr_data = rs2_data;
  assign mem_wr_sig  = is_store & ~reset_n;

endmodule

// File: tb/tb_rv32i_core.sv
// Directed bench for rv32i_core: behavioural ROM/RAM, a table of single-instruction vectors
// and hand-written sequences for reset, Fibonacci, control flow and mid-program reset.

module tb_rv32i_core;

  logic        clk;
  logic        reset_n;
  logic [31:0] instruction;
  logic [31:0] mem_rd_data;
  logic        mem_wr_sig;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_addr;
  logic [31:0] rom_addr;

  logic [31:0] rom [0:255];
  logic [31:0] ram [0:255];
  logic        ram_clr;

  int tests;
  int fails;

  rv32i_core #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .instruction (instruction),
    .mem_rd_data (mem_rd_data),
    .mem_wr_sig  (mem_wr_sig),
    .mem_wr_data (mem_wr_data),
    .mem_addr    (mem_addr),
    .rom_addr    (rom_addr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign instruction = rom[rom_addr[9:2]];
  assign mem_rd_data = ram[mem_addr[9:2]];

  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 256; i++) ram[i] <= 32'h0;
    end else if (mem_wr_sig) begin
      ram[mem_addr[9:2]] <= mem_wr_data;
    end
  end

  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rd, op};
  endfunction

  function automatic logic [31:0] rf(input int idx);
    return dut.reg_file_inst.registers[idx];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 32'h0;
  endtask

  // Hold reset two edges, release on a negedge; instruction 0 is then in flight.
  task automatic start_prog();
    reset_n = 1'b1;
    ram_clr = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    ram_clr = 1'b0;
  endtask

  typedef struct {
    logic [31:0] instr;
    int          rd;
    logic [31:0] exp_val;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
  } vec_t;

  localparam int NVEC = 24;
  vec_t vecs [NVEC];

  localparam int NCF = 12;
  logic [31:0] cf_pc [NCF];

  logic [31:0] acc;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests   = 0;
    fails   = 0;
    reset_n = 1'b1;
    ram_clr = 1'b1;

    vecs[0]  = '{enc_i(32'hFFFFFFF8, 0, 3'd0, 1, 7'h13), 1, 32'hFFFFFFF8, 1'b0, 32'h0, 32'h0};
    vecs[1]  = '{enc_i(32'h401, 1, 3'd5, 2, 7'h13),      2, 32'hFFFFFFFC, 1'b0, 32'h0, 32'h0};
    vecs[2]  = '{enc_i(32'd28, 1, 3'd5, 3, 7'h13),       3, 32'h0000000F, 1'b0, 32'h0, 32'h0};
    vecs[3]  = '{enc_r(7'h00, 0, 1, 3'd2, 4),            4, 32'h00000001, 1'b0, 32'h0, 32'h0};
    vecs[4]  = '{enc_r(7'h00, 0, 1, 3'd3, 5),            5, 32'h00000000, 1'b0, 32'h0, 32'h0};
    vecs[5]  = '{enc_i(32'h55, 0, 3'd0, 6, 7'h13),       6, 32'h00000055, 1'b0, 32'h0, 32'h0};
    vecs[6]  = '{enc_s(32'd8, 6, 0),                     6, 32'h00000055, 1'b1, 32'h8, 32'h55};
    vecs[7]  = '{enc_i(32'd8, 0, 3'd2, 7, 7'h03),        7, 32'h00000055, 1'b0, 32'h0, 32'h0};
    vecs[8]  = '{enc_r(7'h00, 1, 6, 3'd0, 8),            8, 32'h0000004D, 1'b0, 32'h0, 32'h0};
    vecs[9]  = '{enc_r(7'h20, 6, 0, 3'd0, 9),            9, 32'hFFFFFFAB, 1'b0, 32'h0, 32'h0};
    vecs[10] = '{enc_i(32'hFF, 6, 3'd4, 10, 7'h13),      10, 32'h000000AA, 1'b0, 32'h0, 32'h0};
    vecs[11] = '{enc_r(7'h00, 3, 6, 3'd1, 11),           11, 32'h002A8000, 1'b0, 32'h0, 32'h0};
    vecs[12] = '{enc_u(20'h12345, 12, 7'h37),            12, 32'h12345000, 1'b0, 32'h0, 32'h0};
    vecs[13] = '{enc_u(20'h00001, 13, 7'h17),            13, 32'h00001034, 1'b0, 32'h0, 32'h0};
    vecs[14] = '{enc_r(7'h20, 3, 1, 3'd5, 14),           14, 32'hFFFFFFFF, 1'b0, 32'h0, 32'h0};
    vecs[15] = '{enc_i(32'hF0, 1, 3'd7, 15, 7'h13),      15, 32'h000000F0, 1'b0, 32'h0, 32'h0};
    vecs[16] = '{enc_i(32'hFFFFFF00, 6, 3'd6, 16, 7'h13), 16, 32'hFFFFFF55, 1'b0, 32'h0, 32'h0};
    vecs[17] = '{enc_i(32'hFFFFFFFF, 6, 3'd3, 17, 7'h13), 17, 32'h00000001, 1'b0, 32'h0, 32'h0};
    vecs[18] = '{enc_i(32'hFFFFFFF7, 1, 3'd2, 18, 7'h13), 18, 32'h00000000, 1'b0, 32'h0, 32'h0};
    vecs[19] = '{enc_i(32'd7, 0, 3'd0, 0, 7'h13),        0, 32'h00000000, 1'b0, 32'h0, 32'h0};
    vecs[20] = '{32'h00000000,                           1, 32'hFFFFFFF8, 1'b0, 32'h0, 32'h0};
    vecs[21] = '{enc_r(7'h00, 3, 1, 3'd5, 19),           19, 32'h0001FFFF, 1'b0, 32'h0, 32'h0};
    vecs[22] = '{enc_i(32'd1, 14, 3'd0, 21, 7'h13),      21, 32'h00000000, 1'b0, 32'h0, 32'h0};
    vecs[23] = '{enc_i(32'h400, 6, 3'd0, 22, 7'h13),     22, 32'h00000455, 1'b0, 32'h0, 32'h0};

    cf_pc = '{32'd8, 32'd12, 32'd4, 32'd20, 32'd28, 32'd32,
              32'd40, 32'd44, 32'd52, 32'd56, 32'd4, 32'd20};

    // Reset hold with a ROM full of ADDI x1,x1,1.
    for (int i = 0; i < 256; i++) rom[i] = enc_i(32'd1, 1, 3'd0, 1, 7'h13);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_rom_addr", rom_addr, 32'h0);
    check("reset_wr_sig", {31'b0, mem_wr_sig}, 32'h0);
    acc = 32'h0;
    for (int i = 0; i < 32; i++) acc = acc | rf(i);
    check("reset_regs_zero", acc, 32'h0);
    @(negedge clk);
    check("reset_hold_rom_addr", rom_addr, 32'h0);
    reset_n = 1'b0;
    ram_clr = 1'b0;
    @(negedge clk);
    check("release_x1", rf(1), 32'h1);
    check("release_rom_addr", rom_addr, 32'h4);

    // Table-driven straight-line program: one vector retires per cycle.
    clear_rom();
    for (int i = 0; i < NVEC; i++) rom[i] = vecs[i].instr;
    start_prog();
    for (int i = 0; i < NVEC; i++) begin
      check($sformatf("vec%0d_pc", i), rom_addr, 32'(i * 4));
      check($sformatf("vec%0d_wr_sig", i), {31'b0, mem_wr_sig}, {31'b0, vecs[i].exp_we});
      if (vecs[i].exp_we) begin
        check($sformatf("vec%0d_addr", i), mem_addr, vecs[i].exp_addr);
        check($sformatf("vec%0d_wdata", i), mem_wr_data, vecs[i].exp_wdata);
      end
      @(negedge clk);
      check($sformatf("vec%0d_rd", i), rf(vecs[i].rd), vecs[i].exp_val);
    end
    check("ram_word2", ram[2], 32'h55);

    // Iterative Fibonacci: after 10 iterations x1 holds fib(10), copied to x3.
    clear_rom();
    rom[0] = enc_i(32'd0, 0, 3'd0, 1, 7'h13);
    rom[1] = enc_i(32'd1, 0, 3'd0, 2, 7'h13);
    rom[2] = enc_i(32'd10, 0, 3'd0, 5, 7'h13);
    rom[3] = enc_r(7'h00, 2, 1, 3'd0, 6);
    rom[4] = enc_i(32'd0, 2, 3'd0, 1, 7'h13);
    rom[5] = enc_i(32'd0, 6, 3'd0, 2, 7'h13);
    rom[6] = enc_i(32'hFFFFFFFF, 5, 3'd0, 5, 7'h13);
    rom[7] = enc_b(32'hFFFFFFF0, 0, 5, 3'd1);
    rom[8] = enc_i(32'd0, 1, 3'd0, 3, 7'h13);
    rom[9] = enc_j(32'd0, 0);
    start_prog();
    repeat (500) @(negedge clk);
    check("fib_x3", rf(3), 32'd55);
    check("fib_spin_pc", rom_addr, 32'd36);

    // Control flow: jumps, taken/not-taken branches of every flavour, JALR bit0 clear.
    clear_rom();
    rom[0]  = enc_j(32'd8, 1);
    rom[1]  = enc_j(32'd16, 0);
    rom[2]  = enc_b(32'd16, 0, 0, 3'd1);
    rom[3]  = enc_b(32'hFFFFFFF8, 0, 0, 3'd0);
    rom[5]  = enc_i(32'd29, 0, 3'd0, 7, 7'h67);
    rom[7]  = enc_i(32'hFFFFFFFF, 0, 3'd0, 8, 7'h13);
    rom[8]  = enc_b(32'd8, 0, 8, 3'd4);
    rom[10] = enc_b(32'd8, 0, 8, 3'd6);
    rom[11] = enc_b(32'd8, 8, 0, 3'd5);
    rom[13] = enc_b(32'd8, 8, 0, 3'd7);
    rom[14] = enc_i(32'd5, 0, 3'd0, 0, 7'h67);
    start_prog();
    for (int i = 0; i < NCF; i++) begin
      @(negedge clk);
      check($sformatf("cf_step%0d_pc", i), rom_addr, cf_pc[i]);
    end
    check("cf_jal_link", rf(1), 32'd4);
    check("cf_jalr_link", rf(7), 32'd24);
    check("cf_x8", rf(8), 32'hFFFFFFFF);
    check("cf_x0", rf(0), 32'h0);

    // Reset asserted while a store is in flight suppresses the RAM write.
    clear_rom();
    rom[0] = enc_i(32'h77, 0, 3'd0, 1, 7'h13);
    rom[1] = enc_s(32'd12, 1, 0);
    start_prog();
    @(negedge clk);
    check("midrst_x1", rf(1), 32'h77);
    check("midrst_store_sig", {31'b0, mem_wr_sig}, 32'h1);
    reset_n = 1'b1;
    #1;
    check("midrst_sig_gated", {31'b0, mem_wr_sig}, 32'h0);
    @(negedge clk);
    check("midrst_ram", ram[3], 32'h0);
    check("midrst_pc", rom_addr, 32'h0);
    check("midrst_x1_cleared", rf(1), 32'h0);
    reset_n = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
